// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder/subtractor: digit width,
// controller state encoding and the decimal-nine constant.
package bcd_pkg;
    localparam int          BCD_W = 4;
    localparam logic [3:0]  NINE  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [BCD_W-1:0] d);
        return d > NINE;
    endfunction
endpackage

// File: rtl/bcd_addsub_serial_if.sv
// Request/result bundle of the serial BCD adder/subtractor.
// Handshake: start is taken on a clk edge only when busy=0; done pulses for one
// cycle when f/cout/err carry the new result, which then holds until the next done.
interface bcd_addsub_serial_if #(parameter int DIGITS = 4);
    import bcd_pkg::*;

    logic                      start;
    logic                      sub;
    logic                      cin;
    logic [BCD_W*DIGITS-1:0]   a;
    logic [BCD_W*DIGITS-1:0]   b;
    logic                      busy;
    logic                      done;
    logic [BCD_W*DIGITS-1:0]   f;
    logic                      cout;
    logic                      err;

    modport master (output start, sub, cin, a, b,
                    input  busy, done, f, cout, err);
    modport slave  (input  start, sub, cin, a, b,
                    output busy, done, f, cout, err);
endinterface

// File: rtl/bcd_digit_adder.sv
// One decimal digit of addition with the +6 correction; purely combinational.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] a_i,
    input  logic [BCD_W-1:0] b_i,
    input  logic             c_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             c_o
);
    logic [BCD_W:0] s;

    always_comb begin
        s = {1'b0, a_i} + {1'b0, b_i} + {{BCD_W{1'b0}}, c_i};
        if (s > {1'b0, NINE}) begin
            digit_o = BCD_W'(s + 5'd6);
            c_o     = 1'b1;
        end else begin
            digit_o = s[BCD_W-1:0];
            c_o     = 1'b0;
        end
    end
endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD add/subtract: one digit per clock, LSD first, result
// published on the DONE edge and held until the next completion.
module bcd_addsub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_addsub_serial_if.slave   bus_io,
    output state_t               state_o
);
    localparam int W     = BCD_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state_q;
    logic               busy_q, done_q;
    logic [W-1:0]       a_q, b_q, res_q, f_q;
    logic               sub_q, carry_q, cout_q, err_q, err_acc_q;
    logic [IDX_W-1:0]   idx_q;

    logic [BCD_W-1:0]   a_dig, b_dig, b_eff, sum_dig;
    logic               carry_nx, dig_bad, last_dig;
    logic [W-1:0]       res_d;

    // Subtraction is A + (nines complement of B) + 1, the +1 entering as initial carry.
    assign a_dig    = a_q[BCD_W-1:0];
    assign b_dig    = b_q[BCD_W-1:0];
    assign b_eff    = sub_q ? (NINE - b_dig) : b_dig;
    assign dig_bad  = digit_bad(a_dig) | digit_bad(b_dig);
    assign last_dig = (idx_q == IDX_W'(DIGITS - 1));
    assign res_d    = (res_q >> BCD_W) | (W'(sum_dig) << (W - BCD_W));

    bcd_digit_adder u_digit_adder (
        .a_i     (a_dig),
        .b_i     (b_eff),
        .c_i     (carry_q),
        .digit_o (sum_dig),
        .c_o     (carry_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            f_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            err_acc_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q == RUN) begin
                a_q       <= a_q >> BCD_W;
                b_q       <= b_q >> BCD_W;
                res_q     <= res_d;
                carry_q   <= carry_nx;
                err_acc_q <= err_acc_q | dig_bad;
                idx_q     <= idx_q + 1'b1;
                if (last_dig) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    f_q     <= res_d;
                    cout_q  <= carry_nx;
                    err_q   <= err_acc_q | dig_bad;
                end
            end else if (bus_io.start) begin
                // Accepted from IDLE or DONE; DONE->RUN gives back-to-back operation.
                state_q   <= RUN;
                busy_q    <= 1'b1;
                a_q       <= bus_io.a;
                b_q       <= bus_io.b;
                sub_q     <= bus_io.sub;
                carry_q   <= bus_io.sub ? 1'b1 : bus_io.cin;
                res_q     <= '0;
                err_acc_q <= 1'b0;
                idx_q     <= '0;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign bus_io.busy = busy_q;
    assign bus_io.done = done_q;
    assign bus_io.f    = f_q;
    assign bus_io.cout = cout_q;
    assign bus_io.err  = err_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Bench for bcd_addsub_serial: directed cases plus random operands checked
// against an integer-arithmetic decimal model.
module tb_bcd_addsub_serial;
  import bcd_pkg::*;

  localparam int D  = 4;
  localparam int W  = BCD_W * D;
  localparam int CW = W + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  state_t state_dbg;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_addsub_serial_if #(.DIGITS(D)) bus ();

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_io  (bus.slave),
    .state_o (state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard: {err, cout, f}
  logic [CW-1:0] exp_q[$];
  logic [W-1:0]  hold_f;
  logic          hold_cout;
  logic          hold_err;
  bit            hold_known;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit has_bad(input logic [W-1:0] v);
    bit bad = 0;
    for (int i = 0; i < D; i++) if (v[i*4 +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint n);
    logic [W-1:0] r = '0;
    longint x = n;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference; f is don't-care when err is set.
  function automatic logic [CW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic sv, input logic cv);
    longint m = 1;
    longint x, y, r;
    logic co;
    for (int i = 0; i < D; i++) m = m * 10;
    if (has_bad(av) || has_bad(bv)) return {1'b1, 1'b0, {W{1'b0}}};
    x = bcd2int(av);
    y = bcd2int(bv);
    if (sv) begin
      r  = x - y + m;
      co = (x >= y);
    end else begin
      r  = x + y + longint'(cv);
      co = (r >= m);
    end
    return {1'b0, co, int2bcd(r % m)};
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad) r[$urandom_range(0, D - 1)*4 +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  // driver: call at a negedge; returns at the negedge of the done cycle
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input logic cv, input bit mid_start);
    logic [CW-1:0] e;
    int n;
    exp_q.push_back(model(av, bv, sv, cv));
    bus.a = av; bus.b = bv; bus.sub = sv; bus.cin = cv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    check("busy_run", CW'(bus.busy), CW'(1));
    while (bus.done !== 1'b1 && n < 3 * D) begin
      if (n == 2) begin
        if (mid_start) bus.start = 1'b1;
        if (hold_known) begin
          check("f_hold", CW'(bus.f), CW'(hold_f));
          check("cout_hold", CW'(bus.cout), CW'(hold_cout));
        end
      end
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    e = exp_q.pop_front();
    if (bus.done !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL done_timeout observed=%0d cycles expected=%0d", n, D);
    end else begin
      check("latency", CW'(n), CW'(D));
      check("err", CW'(bus.err), CW'(e[W+1]));
      if (!e[W+1]) begin
        check("f", CW'(bus.f), CW'(e[W-1:0]));
        check("cout", CW'(bus.cout), CW'(e[W]));
      end
      check("busy_done", CW'(bus.busy), CW'(0));
    end
    hold_known = !e[W+1];
    hold_f     = e[W-1:0];
    hold_cout  = e[W];
    hold_err   = e[W+1];
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    check(tag, CW'(extra), CW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    hold_known = 1; hold_f = '0; hold_cout = 0; hold_err = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_busy", CW'(bus.busy), CW'(0));
    check("rst_done", CW'(bus.done), CW'(0));
    check("rst_f", CW'(bus.f), CW'(0));
    check("rst_cout", CW'(bus.cout), CW'(0));
    check("rst_err", CW'(bus.err), CW'(0));
    check("rst_state", CW'(state_dbg), CW'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    do_op(16'h1234, 16'h8766, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(16'h0500, 16'h0123, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    do_op(16'h0123, 16'h0500, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("sub_neg_f", CW'(bus.f), CW'(16'h9623));
    do_op(16'h9999, 16'h0000, 1'b0, 1'b1, 1'b1);
    expect_no_done("start_in_run_single_done", 8);
    do_op(16'h00A0, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // back-to-back: start held in the DONE cycle
    do_op(16'h4321, 16'h1111, 1'b1, 1'b0, 1'b0);
    t0 = cyc;
    do_op(16'h0999, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("b2b_spacing", CW'(cyc - t0), CW'(D + 1));
    @(negedge clk);

    // random operations, occasionally back-to-back or with bad digits
    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] ra, rb;
      ra = rand_bcd($urandom_range(0, 7) == 0);
      rb = rand_bcd($urandom_range(0, 7) == 0);
      do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // asynchronous reset in the second RUN cycle
    do_op(16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", CW'(bus.busy), CW'(0));
    check("arst_done", CW'(bus.done), CW'(0));
    check("arst_f", CW'(bus.f), CW'(0));
    check("arst_cout", CW'(bus.cout), CW'(0));
    check("arst_state", CW'(state_dbg), CW'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    hold_known = 1; hold_f = '0; hold_cout = 0; hold_err = 0;
    expect_no_done("arst_no_done", 8);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("post_rst_f", CW'(bus.f), CW'(16'h0002));
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_addsub_serial.md
BCD_ADDSUB_SERIAL -- requirements
Module: bcd_addsub_serial

Interface
REQ-001 The block SHALL have one clock and one reset: the clock port is named clk; the reset port is named rst and is asynchronous and active-high.
REQ-002 Parameter: DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port start  input  1  operation request, sampled on clk edge.
REQ-006 Port sub  input  1  0 = A+B+cin, 1 = A-B; sampled with start.
REQ-007 Port cin  input  1  decimal carry-in; sampled with start; ignored when sub=1.
REQ-008 Port a  input  4*DIGITS  BCD operand A; digit 0 in bits [3:0].
REQ-009 Port b  input  4*DIGITS  BCD operand B; same packing.
REQ-010 Port busy  output  1  high while in RUN.
REQ-011 Port done  output  1  one-cycle completion pulse.
REQ-012 Port f  output  4*DIGITS  BCD result, registered.
REQ-013 Port cout  output  1  final decimal carry; in sub mode 1 means A>=B (no borrow).
REQ-014 Port err  output  1  at least one operand digit was >9.

Function
REQ-015 FSM states: IDLE, RUN, DONE; start SHALL be accepted only in IDLE or DONE, and ignored in RUN.
REQ-016 On acceptance: latch a, b, sub; load the initial carry with cin (add) or 1 (sub); clear digit index to 0; go to RUN.
REQ-017 Each RUN edge SHALL process exactly one digit, LSD first: binary sum s = a_i + b'_i + carry (5 bits), where b'_i = b_i (add) or 9-b_i (sub, modulo 16).
REQ-018 Correction SHALL apply: if s>9, digit = (s+6) mod 16 and next carry = 1; otherwise digit = s and carry = 0.
REQ-019 After the DIGITS-th RUN edge, the state SHALL be DONE, with f, cout and err updated on that same edge; f, cout and err SHALL NOT change during RUN.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unless a start is accepted, in which case it goes to RUN (back-to-back).
REQ-021 Latency: start sampled at edge k gives done=1 in the cycle after edge k+DIGITS, for a throughput of one operation per DIGITS+1 cycles.
REQ-022 In sub mode with cout=0, f SHALL be the ten's complement of |A-B| (no sign conversion).
REQ-023 err SHALL be set if any latched digit of a or b is >9; the result is still computed per REQ-017/018 and is undefined in value but deterministic.
REQ-024 f, cout and err SHALL hold until the next completion.

Reset
REQ-025 rst SHALL force IDLE, with busy=0, done=0, f=0, cout=0, err=0 and all internal registers cleared, immediately and independently of clk.
REQ-026 A reset during RUN SHALL abort the operation with no done pulse; the first start after rst deassertion SHALL behave normally.

Structure
REQ-027 A shared package bcd_pkg SHALL hold: BCD_W=4, the state enumeration (IDLE/RUN/DONE), and the constant NINE=4'd9.
REQ-028 One sub-module, bcd_digit_adder (combinational: 4-bit a, 4-bit b, carry in, 4-bit digit out, carry out, per REQ-017/018), SHALL be instantiated once.
REQ-029 Operands SHALL shift right by 4 per RUN edge; the result SHALL accumulate in an internal shift register and be copied to f on entry to DONE.

Verification (DIGITS=4)
REQ-030 add 1234+8766, cin=0 -> f=0000, cout=1, err=0; done exactly 4 edges after start.
REQ-031 sub 0500-0123 -> f=0377, cout=1; sub 0123-0500 -> f=9623, cout=0.
REQ-032 add 9999+0000, cin=1 -> f=0000, cout=1; start pulsed again during RUN -> ignored, with a single done.
REQ-033 a=00A0, b=0001 add -> err=1 with done; the next valid operation -> err=0.
REQ-034 rst asserted on the 2nd RUN cycle -> all outputs 0 asynchronously with no done; then 0001+0001 -> f=0002.
REQ-035 start held high in the DONE cycle -> the new operation starts and its done follows 5 cycles after the previous done.
